// File: rtl/execute_stage_tr.sv
// rtl/execute_stage_tr.sv - time-redundant execute stage with bounded retry and vote (optional FAULT_INJECT_EN)
module execute_stage_tr #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int MAX_RETRY = 2,
    parameter int FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              ALUSrcE,
    input  logic              BranchE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1_E,
    input  logic [DATA_W-1:0] RD2_E,
    input  logic [DATA_W-1:0] Imm_Ext_E,
    input  logic [DATA_W-1:0] PCE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [DATA_W-1:0] ALU_ResultM_In,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    output logic              out_valid,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [DATA_W-1:0] ALU_ResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] PCPlus4M,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              PCSrcE,
    output logic              fault_detected,
    output logic              fault_uncorrectable,
    output logic [FCNT_W-1:0] fault_count
`ifdef FAULT_INJECT_EN
    ,
    input  logic [DATA_W-1:0]    inj_mask,
    input  logic [MAX_RETRY+1:0] inj_vec
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_PASS1, S_PASS2, S_RETRY, S_COMMIT} state_t;

    state_t              r_state, w_next;
    logic [DATA_W-1:0]   r_src_a, r_src_b, r_op_b, r_pcplus4, r_pctarget;
    logic [DATA_W-1:0]   r_r1, r_r2, r_sel;
    logic [2:0]          r_alu_ctl, r_k;
    logic [REG_AW-1:0]   r_rd;
    logic                r_regwrite, r_memwrite, r_resultsrc, r_branch;
    logic                r_corr, r_uncorr;
    logic [DATA_W-1:0]   w_fwd_a, w_fwd_b, w_alu, w_inj, w_res;
    logic                w_lt, w_match;

    assign in_ready = (r_state == S_IDLE);

    always_comb begin
        case (ForwardA_E)
            2'b01:   w_fwd_a = ResultW;
            2'b10:   w_fwd_a = ALU_ResultM_In;
            default: w_fwd_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = ALU_ResultM_In;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_lt = $signed(r_src_a) < $signed(r_op_b);

    always_comb begin
        case (r_alu_ctl)
            3'b000:  w_alu = r_src_a + r_op_b;
            3'b001:  w_alu = r_src_a - r_op_b;
            3'b010:  w_alu = r_src_a & r_op_b;
            3'b011:  w_alu = r_src_a | r_op_b;
            3'b100:  w_alu = r_src_a ^ r_op_b;
            3'b101:  w_alu = {{(DATA_W-1){1'b0}}, w_lt};
            default: w_alu = '0;
        endcase
    end

`ifdef FAULT_INJECT_EN
    // Pass index: PASS1=0, PASS2=1, retry k=k+1; mask is rotated left by that index.
    logic [2:0]          w_pass;
    logic [2*DATA_W-1:0] w_dbl;
    logic                w_inj_on;
    always_comb begin
        case (r_state)
            S_PASS2: w_pass = 3'd1;
            S_RETRY: w_pass = r_k + 3'd1;
            default: w_pass = 3'd0;
        endcase
        w_dbl    = {inj_mask, inj_mask} << w_pass;
        w_inj_on = 1'b0;
        for (int i = 0; i < MAX_RETRY + 2; i++) begin
            if (w_pass == i[2:0]) w_inj_on = inj_vec[i];
        end
        w_inj = w_inj_on ? w_dbl[2*DATA_W-1:DATA_W] : '0;
    end
`else
    assign w_inj = '0;
`endif

    assign w_res   = w_alu ^ w_inj;
    assign w_match = (w_res == r_r1) || (w_res == r_r2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_PASS1;
            S_PASS1:  w_next = S_PASS2;
            S_PASS2:  begin
                if (w_res == r_r1)      w_next = S_COMMIT;
                else if (MAX_RETRY > 0) w_next = S_RETRY;
                else                    w_next = S_COMMIT;
            end
            S_RETRY:  if (w_match || r_k == 3'(MAX_RETRY)) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_a <= '0; r_src_b <= '0; r_op_b <= '0; r_pcplus4 <= '0; r_pctarget <= '0;
            r_r1 <= '0; r_r2 <= '0; r_sel <= '0; r_alu_ctl <= '0; r_k <= '0; r_rd <= '0;
            r_regwrite <= 1'b0; r_memwrite <= 1'b0; r_resultsrc <= 1'b0; r_branch <= 1'b0;
            r_corr <= 1'b0; r_uncorr <= 1'b0;
            out_valid <= 1'b0; RegWriteM <= 1'b0; MemWriteM <= 1'b0; ResultSrcM <= 1'b0;
            RD_M <= '0; ALU_ResultM <= '0; WriteDataM <= '0; PCPlus4M <= '0; PCTargetE <= '0;
            PCSrcE <= 1'b0; fault_detected <= 1'b0; fault_uncorrectable <= 1'b0; fault_count <= '0;
        end else begin
            // Bubble by default; data registers hold.
            out_valid           <= 1'b0;
            RegWriteM           <= 1'b0;
            MemWriteM           <= 1'b0;
            PCSrcE              <= 1'b0;
            fault_detected      <= 1'b0;
            fault_uncorrectable <= 1'b0;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_src_a     <= w_fwd_a;
                    r_src_b     <= w_fwd_b;
                    r_op_b      <= ALUSrcE ? Imm_Ext_E : w_fwd_b;
                    r_alu_ctl   <= ALUControlE;
                    r_regwrite  <= RegWriteE;
                    r_memwrite  <= MemWriteE;
                    r_resultsrc <= ResultSrcE;
                    r_branch    <= BranchE;
                    r_rd        <= RD_E;
                    r_pcplus4   <= PCPlus4E;
                    r_pctarget  <= PCE + Imm_Ext_E;
                    r_corr      <= 1'b0;
                    r_uncorr    <= 1'b0;
                    r_k         <= 3'd1;
                end
                S_PASS1: r_r1 <= w_res;
                S_PASS2: begin
                    if (w_res == r_r1) begin
                        r_sel <= r_r1;
                    end else begin
                        r_r2 <= w_res;
                        if (MAX_RETRY == 0) r_uncorr <= 1'b1;
                    end
                end
                S_RETRY: begin
                    if (w_match) begin
                        r_sel  <= w_res;
                        r_corr <= 1'b1;
                    end else if (r_k == 3'(MAX_RETRY)) begin
                        r_uncorr <= 1'b1;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                S_COMMIT: begin
                    out_valid  <= 1'b1;
                    RD_M       <= r_rd;
                    WriteDataM <= r_src_b;
                    PCPlus4M   <= r_pcplus4;
                    PCTargetE  <= r_pctarget;
                    ResultSrcM <= r_resultsrc;
                    if (r_uncorr) begin
                        ALU_ResultM         <= r_r1;
                        fault_uncorrectable <= 1'b1;
                    end else begin
                        ALU_ResultM    <= r_sel;
                        RegWriteM      <= r_regwrite;
                        MemWriteM      <= r_memwrite;
                        PCSrcE         <= r_branch && (r_sel == '0);
                        fault_detected <= r_corr;
                        if (r_corr && fault_count != '1) fault_count <= fault_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage_tr.sv
// tb/tb_execute_stage_tr.sv - scoreboard bench for execute_stage_tr against a pass-vote reference model
module tb_execute_stage_tr;
    localparam int DW = 32, AW = 5, MR = 2, FW = 8;

    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic RegWriteE = 0, MemWriteE = 0, ResultSrcE = 0, ALUSrcE = 0, BranchE = 0;
    logic [2:0] ALUControlE = '0;
    logic [DW-1:0] RD1_E = '0, RD2_E = '0, Imm_Ext_E = '0, PCE = '0, PCPlus4E = '0;
    logic [AW-1:0] RD_E = '0;
    logic [DW-1:0] ResultW = '0, ALU_ResultM_In = '0;
    logic [1:0] ForwardA_E = '0, ForwardB_E = '0;
    logic out_valid, RegWriteM, MemWriteM, ResultSrcM, PCSrcE, fault_detected, fault_uncorrectable;
    logic [AW-1:0] RD_M;
    logic [DW-1:0] ALU_ResultM, WriteDataM, PCPlus4M, PCTargetE;
    logic [FW-1:0] fault_count;
    logic [DW-1:0] inj_mask = '0;
    logic [MR+1:0] inj_vec = '0;

    execute_stage_tr #(.DATA_W(DW), .REG_AW(AW), .MAX_RETRY(MR), .FCNT_W(FW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .ResultW(ResultW), .ALU_ResultM_In(ALU_ResultM_In),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .out_valid(out_valid), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .fault_detected(fault_detected),
        .fault_uncorrectable(fault_uncorrectable), .fault_count(fault_count)
`ifdef FAULT_INJECT_EN
        , .inj_mask(inj_mask), .inj_vec(inj_vec)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] alu, wd, pc4, pct;
        logic [AW-1:0] rd;
        logic rw, mw, rs, pcsrc, fd, fu;
        logic [FW-1:0] fcnt;
        int due;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0, n_err = 0;
    int m_fcnt = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    function automatic logic [DW-1:0] alu_ref(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rotl(logic [DW-1:0] m, int p);
        if (p == 0) return m;
        return (m << p) | (m >> (DW - p));
    endfunction

    // Issue one instruction; the expectation is derived from the spec's vote rules.
    task automatic issue(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] imm,
                         logic [DW-1:0] pc, logic alusrc, logic br, logic rw, logic mw, logic rs,
                         logic [AW-1:0] rd, logic [1:0] fa, logic [1:0] fb,
                         logic [DW-1:0] rwv, logic [DW-1:0] rmv);
        exp_t e;
        logic [DW-1:0] sa, sbv, bo, tru, sel;
        logic [DW-1:0] v[MR+2];
        int t, extra;
        logic corr, unc, found;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            fail_timeout("in_ready_wait");
            return;
        end
        in_valid = 1; ALUControlE = op; RD1_E = a; RD2_E = b; Imm_Ext_E = imm; PCE = pc;
        PCPlus4E = pc + 4; ALUSrcE = alusrc; BranchE = br; RegWriteE = rw; MemWriteE = mw;
        ResultSrcE = rs; RD_E = rd; ForwardA_E = fa; ForwardB_E = fb; ResultW = rwv; ALU_ResultM_In = rmv;
        sa  = (fa == 2'b01) ? rwv : (fa == 2'b10) ? rmv : a;
        sbv = (fb == 2'b01) ? rwv : (fb == 2'b10) ? rmv : b;
        bo  = alusrc ? imm : sbv;
        tru = alu_ref(op, sa, bo);
        for (int p = 0; p < MR + 2; p++) v[p] = tru ^ (inj_vec[p] ? rotl(inj_mask, p) : '0);
        corr = 0; unc = 0; extra = 0; sel = v[0];
        if (v[0] != v[1]) begin
            found = 0;
            for (int k = 1; k <= MR; k++) begin
                if (!found && (v[k+1] == v[0] || v[k+1] == v[1])) begin
                    found = 1; sel = v[k+1]; corr = 1; extra = k;
                end
            end
            if (!found) begin
                unc = 1; extra = MR;
            end
        end
        if (corr && m_fcnt < (1 << FW) - 1) m_fcnt++;
        e.alu = unc ? v[0] : sel;
        e.wd = sbv; e.pc4 = pc + 4; e.pct = pc + imm; e.rd = rd;
        e.rw = rw && !unc; e.mw = mw && !unc; e.rs = rs;
        e.pcsrc = !unc && br && (sel == '0);
        e.fd = corr; e.fu = unc; e.fcnt = FW'(m_fcnt);
        @(posedge clk);
        #1;
        e.due = cyc + 3 + extra;
        sb.push_back(e);
        in_valid = 0;
        ResultW = $urandom; ALU_ResultM_In = $urandom; RD1_E = $urandom; RD2_E = $urandom;
        Imm_Ext_E = $urandom; ForwardA_E = 2'($urandom_range(0, 2)); ForwardB_E = 2'($urandom_range(0, 2));
    endtask

    function automatic logic [DW-1:0] rnd_operand();
        logic [DW-1:0] edges[5];
        edges = '{32'h0, 32'h1, 32'h7fffffff, 32'h80000000, 32'hffffffff};
        case ($urandom_range(0, 3))
            0: return edges[$urandom_range(0, 4)];
            1: return DW'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency_cycle", cyc, e.due);
                    chk("ALU_ResultM", ALU_ResultM, e.alu);
                    chk("WriteDataM", WriteDataM, e.wd);
                    chk("PCPlus4M", PCPlus4M, e.pc4);
                    chk("PCTargetE", PCTargetE, e.pct);
                    chk("RD_M", RD_M, e.rd);
                    chk("ctl_rw_mw_rs", {RegWriteM, MemWriteM, ResultSrcM}, {e.rw, e.mw, e.rs});
                    chk("PCSrcE", PCSrcE, e.pcsrc);
                    chk("fault_flags", {fault_detected, fault_uncorrectable}, {e.fd, e.fu});
                    chk("fault_count", fault_count, e.fcnt);
                end
            end else begin
                chk("bubble", {PCSrcE, RegWriteM, MemWriteM, fault_detected, fault_uncorrectable}, 5'b0);
            end
        end
    end

    initial begin
        int t;
        logic [2:0] op;
        logic [DW-1:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", {ALU_ResultM, WriteDataM}, 64'h0);
        chk("reset_pc", {PCPlus4M, PCTargetE}, 64'h0);
        chk("reset_ctl", {out_valid, RegWriteM, MemWriteM, ResultSrcM, PCSrcE, RD_M,
                          fault_detected, fault_uncorrectable, fault_count}, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("idle_in_ready", in_ready, 1);

        issue(3'd0, 5, 0, 7, 32'h40, 1, 0, 1, 0, 0, 5'd3, 2'b00, 2'b00, 0, 0);
        issue(3'd1, 0, 40, 0, 32'h44, 0, 0, 1, 0, 0, 5'd4, 2'b01, 2'b00, 100, 0);
        issue(3'd1, 9, 9, 32'h20, 32'h100, 0, 1, 0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 0);
`ifdef FAULT_INJECT_EN
        inj_mask = 1; inj_vec = 4'b0001;
        issue(3'd0, 2, 0, 2, 32'h200, 1, 0, 1, 0, 0, 5'd5, 2'b00, 2'b00, 0, 0);
        inj_vec = 4'b1111;
        issue(3'd0, 2, 0, 2, 32'h204, 1, 0, 1, 1, 0, 5'd6, 2'b00, 2'b00, 0, 0);
        inj_vec = '0;
`endif

        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = ($urandom_range(0, 4) == 0) ? a : rnd_operand();
`ifdef FAULT_INJECT_EN
            @(negedge clk);
            while (!in_ready) @(negedge clk);
            inj_mask = ($urandom_range(0, 1) == 0) ? 1 : $urandom;
            inj_vec = ($urandom_range(0, 2) == 0) ? (MR+2)'($urandom) : '0;
`endif
            issue(op, a, b, rnd_operand(), $urandom & ~32'h3, 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), $urandom, $urandom);
        end

        // Reset while the instruction sits in PASS2: it must vanish without a commit.
        issue(3'd0, 1, 1, 0, 32'h300, 0, 0, 1, 0, 0, 5'd7, 2'b00, 2'b00, 0, 0);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("midrst_data", {ALU_ResultM, WriteDataM}, 64'h0);
        chk("midrst_ctl", {out_valid, RegWriteM, MemWriteM, PCSrcE, fault_count}, 0);
        sb.delete();
        m_fcnt = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        repeat (6) @(negedge clk);

        for (int n = 0; n < 10; n++)
            issue(3'($urandom_range(0, 5)), rnd_operand(), rnd_operand(), rnd_operand(), $urandom & ~32'h3,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  2'b00, 2'b00, 0, 0);

        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) fail_timeout("drain_out_valid");
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/execute_stage_tr.md
Name: execute_stage_tr

Overview:
Parametrised time-redundant execute stage that replaces the fixed single-recompute EX stage. Operands are captured once on an input handshake. The ALU is then evaluated on successive cycles; mismatching passes are resolved by bounded retry with a vote. The EX/MEM register is written only on a verified commit and inserts bubbles otherwise. Sits between ID/EX and the memory stage; the hazard unit stalls on in_ready.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, destination register address width
MAX_RETRY, 2, extra ALU passes allowed after a pass1/pass2 mismatch (0..6)
FCNT_W, 8, width of the saturating corrected-fault counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
in_valid  input  1  ID/EX holds a valid instruction
in_ready  output  1  stage accepts an instruction this cycle
RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE  input  1 each  control bits
ALUControlE  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed); others give 0
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  input  DATA_W  operands and PC
RD_E  input  REG_AW  destination register
ResultW, ALU_ResultM_In  input  DATA_W  forwarding sources
ForwardA_E, ForwardB_E  input  2  00 regfile, 01 ResultW, 10 ALU_ResultM_In
out_valid  output  1  one-cycle pulse: EX/MEM holds a newly committed instruction
RegWriteM, MemWriteM, ResultSrcM  output  1  registered controls
RD_M  output  REG_AW  registered destination register
ALU_ResultM, WriteDataM, PCPlus4M, PCTargetE  output  DATA_W  registered results
PCSrcE  output  1  branch taken; pulses with out_valid
fault_detected  output  1  pulse: corrected mismatch committed
fault_uncorrectable  output  1  pulse: retries exhausted
fault_count  output  FCNT_W  saturating count of corrected faults

Behaviour:
- Reset clears every output and register to 0 and sets state to IDLE. Reset mid-operation discards the in-flight instruction; no commit occurs.
- States: IDLE, PASS1, PASS2, RETRY, COMMIT.
- IDLE: in_ready=1. On in_valid, capture forwarded SrcA, forwarded SrcB (also used as WriteData), ALU B operand (Imm if ALUSrcE else SrcB), controls, RD, PCPlus4 and PCE+Imm. Next state PASS1.
- Forwarding muxes are sampled only at capture. Later changes on ResultW and ALU_ResultM_In have no effect on the in-flight instruction.
- PASS1: store r1 = ALU(captured operands). Next state PASS2.
- PASS2: compute r2. If r2==r1, select r1 and go to COMMIT. Otherwise store r2, then go to RETRY if MAX_RETRY>0, else to COMMIT with the uncorrectable flag set.
- RETRY, pass k (k=1..MAX_RETRY): compute rk.
  - rk==r1 or rk==r2: select rk, set corrected flag, go to COMMIT.
  - Otherwise, after pass k==MAX_RETRY: go to COMMIT with the uncorrectable flag set.
- COMMIT: in_ready=0. At the clock edge, load the EX/MEM registers from the selected result. Zero = (selected==0); PCSrcE = Zero & Branch.
  - Assert out_valid for that one cycle. Assert fault_detected if corrected. fault_count increments and saturates at 2^FCNT_W-1.
  - If uncorrectable: ALU_ResultM=r1, RegWriteM=0, MemWriteM=0, PCSrcE=0, fault_uncorrectable=1.
  - Next state IDLE.
- Non-commit cycles: RegWriteM, MemWriteM, PCSrcE and out_valid are 0 (bubble). Data registers hold their values.
- Latency: accept at edge T; no-fault out_valid is seen in cycle T+3. Each retry adds 1 cycle. Throughput is 1 instruction per 4 cycles without faults.
- Arithmetic wraps modulo 2^DATA_W. slt produces 0 or 1, zero-extended.

Optional Feature:
FAULT_INJECT_EN: adds inputs inj_mask (DATA_W) and inj_vec (MAX_RETRY+2). The result of pass index p (0=PASS1, 1=PASS2, 2.. = retries) is XORed with inj_mask rotated left by p whenever inj_vec[p]=1. Without the macro these ports are absent and the ALU result is used unmodified.

Test Plan:
- Reset low mid-PASS2, then release -> all outputs 0, state IDLE, no out_valid.
- add RD1=5, Imm=7, ALUSrc=1, RegWrite=1, RD=3 -> out_valid in cycle T+3, ALU_ResultM=12, RD_M=3, RegWriteM=1, fault_count=0.
- ForwardA=01, ResultW=100 at capture then changed to 0; sub with RD2=40 -> ALU_ResultM=60.
- FAULT_INJECT_EN, inj_mask=1, inj_vec=0001, add 2+2 -> r1=5, r2=4, retry pass=4 -> ALU_ResultM=4, fault_detected pulse, fault_count=1, one extra cycle of latency.
- inj_mask=1, inj_vec all ones, MAX_RETRY=2 -> passes differ, fault_uncorrectable pulse, RegWriteM=0, MemWriteM=0, fault_count unchanged.
- beq-style sub 9-9, BranchE=1, PCE=0x100, Imm=0x20 -> PCSrcE pulse with out_valid, PCTargetE=0x120; PCSrcE=0 on all other cycles.
